sd_spi_responder: RTL and testbench
===================================

Name: sd_spi_responder

Overview:
- SD-card-side responder for the SPI-mode command interface.
- Hunts command frames on mosi, decodes index, argument and CRC, and returns R1/R7 responses on miso.
- For CMD17 it serves one data block (0xFE token, payload, CRC16) pulled from a byte-stream backend.
- Used as a card model for host-side bring-up and as an FPGA card emulator.
- Signalling is one bit per clk, MSB first.

Parameters:
- BLOCK_BYTES, 512: payload bytes per CMD17 block.
- NCR_BYTES, 1: 0xFF bytes between the command's last bit and R1 (range 1..8).
- NAC_MIN_BYTES, 1: minimum 0xFF bytes between the end of R1 and the 0xFE token.
- CRC_EN, 1: 1 = send a real CRC16 over the payload; 0 = send 0xFFFF.

Ports:
- clk  in  1  system clock; one SPI bit per cycle.
- reset  in  1  asynchronous, active-high reset.
- cs_n  in  1  chip select, active low.
- mosi  in  1  host-to-card bit.
- miso  out  1  card-to-host bit; 1 when idle.
- cmd_strobe  out  1  one-cycle pulse when a frame is decoded.
- cmd_index  out  6  last decoded command index.
- cmd_arg  out  32  last decoded argument.
- in_idle  out  1  R1 idle bit state.
- rd_start  out  1  one-cycle pulse that starts a block read.
- rd_addr  out  32  block address; valid at rd_start and held until the next rd_start.
- rd_data  in  8  backend byte.
- rd_valid  in  1  rd_data valid.
- rd_ready  out  1  responder accepts rd_data this cycle.
- rd_abort  out  1  one-cycle pulse: the block is abandoned.
- underrun  out  1  sticky flag; cleared at the next cmd_strobe.

Behaviour:
- Reset and cs_n=1
  - Reset values: miso=1, rd_*=0, cmd_strobe=0, cmd_index=0, cmd_arg=0, in_idle=1, underrun=0, app_flag=0, FSM=HUNT.
  - cs_n=1 in any state forces miso=1 and FSM=HUNT the same cycle.
  - If this happens in DATA_WAIT/TOKEN/DATA/CRC, rd_abort pulses for one cycle.
- HUNT: shift mosi while cs_n=0. On start bits 0,1, go to RX for 46 more bits (index[5:0], arg[31:0], crc7[6:0], end bit).
- Decode happens the cycle after the end bit:
  - cmd_strobe pulses; cmd_index and cmd_arg update; underrun clears.
  - An end bit of 0 is treated as a framing error: no response, FSM=HUNT.
- R1 = {0, 0, 0, 0, crc_err, illegal, 0, in_idle}.
  - crc_err is set only for CMD0 whose crc7 byte ≠ 0x95.
- Command decode:
  - CMD0: in_idle←1 (unless crc_err); R1.
  - CMD8: R7 = R1, 0x00, 0x00, 0x01, arg[7:0].
  - CMD55: R1; app_flag←1.
  - ACMD41 (index 41 with app_flag=1): in_idle←0; R1=0x00.
  - CMD17 with in_idle=0: R1=0x00, then the read sequence.
  - CMD17 with in_idle=1: R1=0x05, no data.
  - Any other index: R1 = in_idle|0x04.
  - app_flag clears on any command other than CMD55.
- NCR: after decode, output NCR_BYTES×8 ones, then the response bytes MSB first.
- Read sequence:
  - rd_start pulses with rd_addr=arg in the first cycle of the R1 byte.
  - After R1, go to DATA_WAIT: output ones for at least NAC_MIN_BYTES×8 cycles, always in whole bytes.
  - rd_ready=1 while the one-byte holding buffer is empty; a transfer occurs on rd_valid & rd_ready.
  - Leave DATA_WAIT at the first byte boundary where the minimum gap has elapsed and the buffer is full; send 0xFE.
  - DATA: at each byte boundary move the buffer into the shifter.
  - Underrun: if the buffer is empty at a boundary, set underrun, pulse rd_abort, output ones, FSM=HUNT.
  - rd_ready=0 once BLOCK_BYTES have been accepted.
- CRC16 (CCITT polynomial 0x1021, init 0) is computed over the payload bits as they are shifted out and sent MSB first; FSM then returns to HUNT.
- mosi is ignored outside HUNT/RX. A frame starting during a response is not detected.
- Counters: bit counter 3 bits; byte counter clog2(BLOCK_BYTES+1) bits, saturating, with no wrap.

Decomposition:
- Package sd_pkg:
  - FSM enum: HUNT, RX, NCR, RESP, DATA_WAIT, TOKEN, DATA, CRC.
  - Command indices CMD0, CMD8, CMD17, CMD41, CMD55.
  - Constants: R1 bit positions, TOKEN_START=8'hFE, CMD0_CRC=8'h95.
- Sub-module sd_crc16: serial bit-in CRC16 with clear and enable inputs; shared later by the write path.

Test Plan:
- CMD0 frame 40 00 00 00 00 95 → 8 cycles of 1 (NCR=1), then R1=0x01; cmd_strobe once; in_idle=1.
- CMD0 with crc 0x00 → R1=0x09; in_idle unchanged.
- CMD8 arg 0x000001AA → bytes 01 00 00 01 AA; then CMD99-style index 63 → R1=0x05.
- CMD55 then CMD41 → R1 0x01 then 0x00; in_idle=0. A bare CMD41 without a preceding CMD55 → R1=0x05.
- After init, CMD17 arg 5, backend supplies bytes 0..511 with 3-cycle latency:
  - rd_start with rd_addr=5.
  - R1 00, ≥1 FF, FE, bytes 0x00..0xFF twice, CRC16 matching the reference model; no underrun.
- Error cases, each from a CMD17 start:
  - Deassert cs_n at payload byte 100 → miso=1 the same cycle, rd_abort pulse, next CMD0 decoded normally.
  - Withhold rd_valid at byte 10 → underrun=1 and rd_abort.

Source files
------------

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared types and constants for the SD SPI-mode responder
package sd_pkg;

    typedef enum logic [2:0] {
        HUNT, RX, NCR, RESP, DATA_WAIT, TOKEN, DATA, CRC
    } sd_state_e;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;

    localparam int R1_IDLE_BIT    = 0;
    localparam int R1_ILLEGAL_BIT = 2;
    localparam int R1_CRC_ERR_BIT = 3;

    localparam logic [7:0] TOKEN_START = 8'hFE;
    localparam logic [7:0] CMD0_CRC    = 8'h95;

    function automatic logic [7:0] r1_byte(input logic crc_err, input logic illegal,
                                           input logic idle);
        logic [7:0] r;
        r                 = '0;
        r[R1_CRC_ERR_BIT] = crc_err;
        r[R1_ILLEGAL_BIT] = illegal;
        r[R1_IDLE_BIT]    = idle;
        return r;
    endfunction

endpackage

// File: rtl/sd_crc16.sv
// rtl/sd_crc16.sv - serial CRC16-CCITT (poly 0x1021, init 0), one bit per enabled cycle
module sd_crc16
    import sd_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = {crc_q[14:0], 1'b0} ^ ({16{crc_q[15] ^ bit_i}} & 16'h1021);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q <= '0;
        end else if (clr_i) begin
            crc_q <= '0;
        end else if (en_i) begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_spi_responder.sv
// rtl/sd_spi_responder.sv - card-side SPI command responder with single-block CMD17 reads
module sd_spi_responder
    import sd_pkg::*;
#(
    parameter int BLOCK_BYTES   = 512,
    parameter int NCR_BYTES     = 1,
    parameter int NAC_MIN_BYTES = 1,
    parameter int CRC_EN        = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        cmd_strobe,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        in_idle,
    output logic        rd_start,
    output logic [31:0] rd_addr,
    input  logic [7:0]  rd_data,
    input  logic        rd_valid,
    output logic        rd_ready,
    output logic        rd_abort,
    output logic        underrun
);

    // Byte counter also times NCR (up to 8 bytes), so never narrower than 4 bits.
    localparam int CW = ($clog2(BLOCK_BYTES + 1) > 4) ? $clog2(BLOCK_BYTES + 1) : 4;

    sd_state_e   state_q, state_d;
    logic        prev_q, prev_d;
    logic [44:0] rx_sr_q, rx_sr_d;
    logic [5:0]  rx_cnt_q, rx_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d, byte_inc;
    logic [CW-1:0] acc_cnt_q, acc_cnt_d, acc_inc;
    logic [39:0] sh_q, sh_d;
    logic [2:0]  resp_len_q, resp_len_d;
    logic        read_q, read_d;
    logic [7:0]  buf_q, buf_d;
    logic        buf_full_q, buf_full_d;
    logic        cmd_strobe_q, cmd_strobe_d;
    logic [5:0]  cmd_index_q, cmd_index_d;
    logic [31:0] cmd_arg_q, cmd_arg_d;
    logic        in_idle_q, in_idle_d;
    logic        app_flag_q, app_flag_d;
    logic        underrun_q, underrun_d;
    logic        rd_start_q, rd_start_d;
    logic [31:0] rd_addr_q, rd_addr_d;

    logic [45:0] frame;
    logic [5:0]  f_idx;
    logic [31:0] f_arg;
    logic [7:0]  f_crc;
    logic        dec_idle, dec_app, dec_read, crc_err, illegal;
    logic [2:0]  dec_len;
    logic [31:0] dec_extra;
    logic [7:0]  dec_r1;
    logic        crc_clr, crc_en, read_active, byte_end;
    logic [15:0] crc_val;
    logic [3:0]  crc_idx;

    assign frame       = {rx_sr_q, mosi};
    assign f_idx       = frame[45:40];
    assign f_arg       = frame[39:8];
    assign f_crc       = frame[7:0];
    assign byte_end    = (bit_cnt_q == 3'd7);
    assign byte_inc    = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + 1'b1;
    assign acc_inc     = (&acc_cnt_q) ? acc_cnt_q : acc_cnt_q + 1'b1;
    assign crc_idx     = 4'd15 - {byte_cnt_q[0], bit_cnt_q};
    assign read_active = (state_q == DATA_WAIT) || (state_q == TOKEN) ||
                         (state_q == DATA) || (state_q == CRC);
    assign rd_ready    = !cs_n && !buf_full_q && (acc_cnt_q < CW'(BLOCK_BYTES)) &&
                         ((state_q == DATA_WAIT) || (state_q == TOKEN) || (state_q == DATA));

    // Response content for the frame completing this cycle.
    always_comb begin
        dec_idle  = in_idle_q;
        dec_app   = 1'b0;
        dec_read  = 1'b0;
        dec_len   = 3'd1;
        dec_extra = '1;
        crc_err   = 1'b0;
        illegal   = 1'b0;
        case (f_idx)
            CMD0: begin
                crc_err = (f_crc != CMD0_CRC);
                if (!crc_err) dec_idle = 1'b1;
            end
            CMD8: begin
                dec_len   = 3'd5;
                dec_extra = {24'h000001, f_arg[7:0]};
            end
            CMD55: dec_app = 1'b1;
            CMD41: begin
                if (app_flag_q) dec_idle = 1'b0;
                else            illegal  = 1'b1;
            end
            CMD17: begin
                if (in_idle_q) illegal  = 1'b1;
                else           dec_read = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        dec_r1 = r1_byte(crc_err, illegal, dec_idle);
    end

    always_comb begin
        state_d      = state_q;
        prev_d       = 1'b1;
        rx_sr_d      = rx_sr_q;
        rx_cnt_d     = rx_cnt_q;
        bit_cnt_d    = bit_cnt_q + 3'd1;
        byte_cnt_d   = byte_cnt_q;
        acc_cnt_d    = acc_cnt_q;
        sh_d         = sh_q;
        resp_len_d   = resp_len_q;
        read_d       = read_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        cmd_strobe_d = 1'b0;
        cmd_index_d  = cmd_index_q;
        cmd_arg_d    = cmd_arg_q;
        in_idle_d    = in_idle_q;
        app_flag_d   = app_flag_q;
        underrun_d   = underrun_q;
        rd_start_d   = 1'b0;
        rd_addr_d    = rd_addr_q;
        crc_clr      = 1'b0;
        crc_en       = 1'b0;
        miso         = 1'b1;
        rd_abort     = 1'b0;

        if (rd_valid && rd_ready) begin
            buf_d      = rd_data;
            buf_full_d = 1'b1;
            acc_cnt_d  = acc_inc;
        end

        if (cs_n) begin
            state_d   = HUNT;
            bit_cnt_d = '0;
            rd_abort  = read_active;
        end else begin
            case (state_q)
                HUNT: begin
                    prev_d    = mosi;
                    bit_cnt_d = '0;
                    if (!prev_q && mosi) begin
                        state_d  = RX;
                        rx_cnt_d = '0;
                    end
                end
                RX: begin
                    rx_sr_d  = {rx_sr_q[43:0], mosi};
                    rx_cnt_d = rx_cnt_q + 6'd1;
                    if (rx_cnt_q == 6'd45) begin
                        cmd_strobe_d = 1'b1;
                        cmd_index_d  = f_idx;
                        cmd_arg_d    = f_arg;
                        underrun_d   = 1'b0;
                        bit_cnt_d    = '0;
                        byte_cnt_d   = '0;
                        if (frame[0]) begin
                            state_d    = NCR;
                            in_idle_d  = dec_idle;
                            app_flag_d = dec_app;
                            read_d     = dec_read;
                            resp_len_d = dec_len;
                            sh_d       = {dec_r1, dec_extra};
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                NCR: begin
                    if (byte_end) begin
                        byte_cnt_d = byte_inc;
                        if (byte_inc == CW'(NCR_BYTES)) begin
                            state_d    = RESP;
                            byte_cnt_d = '0;
                            if (read_q) begin
                                rd_start_d = 1'b1;
                                rd_addr_d  = cmd_arg_q;
                                buf_full_d = 1'b0;
                                acc_cnt_d  = '0;
                                crc_clr    = 1'b1;
                            end
                        end
                    end
                end
                RESP: begin
                    miso = sh_q[39];
                    sh_d = {sh_q[38:0], 1'b1};
                    if (byte_end) begin
                        byte_cnt_d = byte_inc;
                        if (byte_inc == CW'(resp_len_q)) begin
                            byte_cnt_d = '0;
                            state_d    = read_q ? DATA_WAIT : HUNT;
                        end
                    end
                end
                DATA_WAIT: begin
                    if (byte_end) begin
                        byte_cnt_d = byte_inc;
                        if (byte_inc >= CW'(NAC_MIN_BYTES) && buf_full_q) begin
                            state_d    = TOKEN;
                            sh_d       = {TOKEN_START, 32'hFFFF_FFFF};
                            byte_cnt_d = '0;
                        end
                    end
                end
                TOKEN: begin
                    miso = sh_q[39];
                    sh_d = {sh_q[38:0], 1'b1};
                    if (byte_end) begin
                        state_d    = DATA;
                        sh_d       = {buf_q, 32'hFFFF_FFFF};
                        buf_full_d = 1'b0;
                        byte_cnt_d = CW'(1);
                    end
                end
                DATA: begin
                    // byte_cnt_q here counts payload bytes already moved into the shifter.
                    miso   = sh_q[39];
                    sh_d   = {sh_q[38:0], 1'b1};
                    crc_en = 1'b1;
                    if (byte_end) begin
                        if (byte_cnt_q == CW'(BLOCK_BYTES)) begin
                            state_d    = CRC;
                            byte_cnt_d = '0;
                        end else if (buf_full_q) begin
                            sh_d       = {buf_q, 32'hFFFF_FFFF};
                            buf_full_d = 1'b0;
                            byte_cnt_d = byte_inc;
                        end else begin
                            underrun_d = 1'b1;
                            rd_abort   = 1'b1;
                            state_d    = HUNT;
                        end
                    end
                end
                CRC: begin
                    miso = (CRC_EN != 0) ? crc_val[crc_idx] : 1'b1;
                    if (byte_end) begin
                        byte_cnt_d = byte_inc;
                        if (byte_cnt_q == CW'(1)) state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= HUNT;
            prev_q       <= 1'b1;
            rx_sr_q      <= '0;
            rx_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            acc_cnt_q    <= '0;
            sh_q         <= '1;
            resp_len_q   <= 3'd1;
            read_q       <= 1'b0;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            cmd_strobe_q <= 1'b0;
            cmd_index_q  <= '0;
            cmd_arg_q    <= '0;
            in_idle_q    <= 1'b1;
            app_flag_q   <= 1'b0;
            underrun_q   <= 1'b0;
            rd_start_q   <= 1'b0;
            rd_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            rx_sr_q      <= rx_sr_d;
            rx_cnt_q     <= rx_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            acc_cnt_q    <= acc_cnt_d;
            sh_q         <= sh_d;
            resp_len_q   <= resp_len_d;
            read_q       <= read_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            cmd_strobe_q <= cmd_strobe_d;
            cmd_index_q  <= cmd_index_d;
            cmd_arg_q    <= cmd_arg_d;
            in_idle_q    <= in_idle_d;
            app_flag_q   <= app_flag_d;
            underrun_q   <= underrun_d;
            rd_start_q   <= rd_start_d;
            rd_addr_q    <= rd_addr_d;
        end
    end

    sd_crc16 u_crc16 (
        .clk_i (clk),
        .rst_i (reset),
        .clr_i (crc_clr),
        .en_i  (crc_en),
        .bit_i (sh_q[39]),
        .crc_o (crc_val)
    );

    assign cmd_strobe = cmd_strobe_q;
    assign cmd_index  = cmd_index_q;
    assign cmd_arg    = cmd_arg_q;
    assign in_idle    = in_idle_q;
    assign rd_start   = rd_start_q;
    assign rd_addr    = rd_addr_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// tb/tb_sd_spi_responder.sv - directed vector bench for sd_spi_responder
module tb_sd_spi_responder;

    localparam int BB = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        cmd_strobe;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        in_idle;
    logic        rd_start;
    logic [31:0] rd_addr;
    logic [7:0]  rd_data = 8'h00;
    logic        rd_valid = 1'b0;
    logic        rd_ready;
    logic        rd_abort;
    logic        underrun;

    always #5 clk = ~clk;

    sd_spi_responder #(
        .BLOCK_BYTES(BB), .NCR_BYTES(1), .NAC_MIN_BYTES(1), .CRC_EN(1)
    ) dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .cmd_strobe(cmd_strobe), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .in_idle(in_idle), .rd_start(rd_start), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_abort(rd_abort), .underrun(underrun)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse monitor, sampled mid-cycle.
    int          n_strobe = 0;
    int          n_start  = 0;
    int          n_abort  = 0;
    logic [31:0] last_addr = '0;
    always @(negedge clk) begin
        #2;
        if (cmd_strobe === 1'b1) n_strobe++;
        if (rd_start === 1'b1) begin
            n_start++;
            last_addr = rd_addr;
        end
        if (rd_abort === 1'b1) n_abort++;
    end

    // Backend: byte i carries i[7:0], a few cycles of latency after each transfer.
    int   be_gen = 0;
    int   be_hold = -1;
    int   be_seen = 0;
    int   be_idx = 0;
    int   be_wait = 0;
    logic be_will = 1'b0;
    always @(negedge clk) begin
        #3;
        if (be_seen != be_gen) begin
            be_seen  = be_gen;
            be_idx   = 0;
            be_wait  = 3;
            rd_valid = 1'b0;
            be_will  = 1'b0;
        end
        if (be_will) begin
            be_idx++;
            rd_valid = 1'b0;
            be_wait  = 3;
        end
        if (!rd_valid) begin
            if (be_wait > 0) be_wait--;
            else if (be_idx < BB && be_idx != be_hold) begin
                rd_data  = be_idx[7:0];
                rd_valid = 1'b1;
            end
        end
        be_will = rd_valid & rd_ready;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic bit_cycle(input logic b, output logic m);
        @(negedge clk);
        mosi = b;
        #1;
        m = miso;
    endtask

    task automatic idle_bits(input int n);
        logic m;
        repeat (n) bit_cycle(1'b1, m);
    endtask

    task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
        logic [47:0] f;
        logic        m;
        f = {2'b01, idx, arg, crc};
        for (int i = 47; i >= 0; i--) bit_cycle(f[i], m);
    endtask

    task automatic read_byte(output logic [7:0] b);
        logic m;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_cycle(1'b1, m);
            b = {b[6:0], m};
        end
    endtask

    task automatic get_r1(output int ones, output logic [7:0] r1);
        logic m;
        ones = 0;
        m    = 1'b1;
        r1   = 8'hFF;
        while (m == 1'b1 && ones < 200) begin
            bit_cycle(1'b1, m);
            if (m) ones++;
        end
        if (m) begin
            total++;
            bad++;
            $display("FAIL r1_timeout: got no response start bit within %0d cycles", ones);
        end else begin
            r1 = 8'h00;
            for (int i = 0; i < 7; i++) begin
                bit_cycle(1'b1, m);
                r1 = {r1[6:0], m};
            end
        end
    endtask

    task automatic cmd_r1(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc,
                          input logic [7:0] exp_r1, input string name);
        int         ones;
        logic [7:0] r1;
        idle_bits(4);
        send_frame(idx, arg, crc);
        get_r1(ones, r1);
        check({name, "_ncr"}, ones, 8);
        check({name, "_r1"}, r1, exp_r1);
    endtask

    function automatic logic [15:0] crc_ref(input int n);
        logic [15:0] c;
        logic [7:0]  d;
        c = '0;
        for (int i = 0; i < n; i++) begin
            d = i[7:0];
            for (int k = 7; k >= 0; k--) begin
                if (c[15] ^ d[k]) c = {c[14:0], 1'b0} ^ 16'h1021;
                else              c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    task automatic read_to_token(output int gap, output logic [7:0] b);
        read_byte(b);
        gap = 0;
        while (b == 8'hFF && gap < 64) begin
            gap++;
            read_byte(b);
        end
    endtask

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [7:0]  crc;
        logic [7:0]  r1;
        int          extra_n;
        logic [31:0] extra;
        logic        idle;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          ones, gap, errs, s0, st0, ab0;
        logic [7:0]  r1, b, c1, c0;
        logic [31:0] ex;
        logic        m;

        vecs[0] = '{6'd0,  32'h0000_0000, 8'h95, 8'h01, 0, 32'h0, 1'b1};
        vecs[1] = '{6'd0,  32'h0000_0000, 8'h01, 8'h09, 0, 32'h0, 1'b1};
        vecs[2] = '{6'd8,  32'h0000_01AA, 8'h87, 8'h01, 4, 32'h0000_01AA, 1'b1};
        vecs[3] = '{6'd63, 32'h0000_0000, 8'h01, 8'h05, 0, 32'h0, 1'b1};
        vecs[4] = '{6'd41, 32'h4000_0000, 8'h01, 8'h05, 0, 32'h0, 1'b1};
        vecs[5] = '{6'd17, 32'h0000_0005, 8'h01, 8'h05, 0, 32'h0, 1'b1};
        vecs[6] = '{6'd55, 32'h0000_0000, 8'h65, 8'h01, 0, 32'h0, 1'b1};
        vecs[7] = '{6'd41, 32'h4000_0000, 8'h77, 8'h00, 0, 32'h0, 1'b0};

        reset = 1'b1;
        cs_n  = 1'b1;
        mosi  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_miso", miso, 1);
        check("rst_strobe", cmd_strobe, 0);
        check("rst_index", cmd_index, 0);
        check("rst_arg", cmd_arg, 0);
        check("rst_idle", in_idle, 1);
        check("rst_underrun", underrun, 0);
        check("rst_rd", {rd_start, rd_ready, rd_abort, rd_addr}, 0);
        @(negedge clk);
        reset = 1'b0;
        cs_n  = 1'b0;

        for (int v = 0; v < 8; v++) begin
            s0  = n_strobe;
            st0 = n_start;
            idle_bits(4);
            send_frame(vecs[v].idx, vecs[v].arg, vecs[v].crc);
            get_r1(ones, r1);
            check($sformatf("v%0d_ncr", v), ones, 8);
            check($sformatf("v%0d_r1", v), r1, vecs[v].r1);
            if (vecs[v].extra_n == 4) begin
                for (int k = 0; k < 4; k++) begin
                    read_byte(b);
                    ex = {ex[23:0], b};
                end
                check($sformatf("v%0d_r7", v), ex, vecs[v].extra);
            end
            check($sformatf("v%0d_strobes", v), n_strobe - s0, 1);
            check($sformatf("v%0d_index", v), cmd_index, vecs[v].idx);
            check($sformatf("v%0d_arg", v), cmd_arg, vecs[v].arg);
            check($sformatf("v%0d_idle", v), in_idle, vecs[v].idle);
            check($sformatf("v%0d_nostart", v), n_start - st0, 0);
        end

        // Full block read.
        st0 = n_start;
        ab0 = n_abort;
        be_hold = -1;
        be_gen++;
        cmd_r1(6'd17, 32'd5, 8'h01, 8'h00, "rd");
        check("rd_start_cnt", n_start - st0, 1);
        check("rd_addr", last_addr, 32'd5);
        read_to_token(gap, b);
        check("rd_gap", gap >= 1, 1);
        check("rd_token", b, 8'hFE);
        errs = 0;
        for (int i = 0; i < BB; i++) begin
            read_byte(b);
            if (b !== i[7:0]) errs++;
        end
        check("rd_payload_errs", errs, 0);
        read_byte(c1);
        read_byte(c0);
        check("rd_crc16", {c1, c0}, crc_ref(BB));
        read_byte(b);
        check("rd_after_crc", b, 8'hFF);
        check("rd_underrun", underrun, 0);
        check("rd_no_abort", n_abort - ab0, 0);

        // Chip select dropped at payload byte 100.
        ab0 = n_abort;
        be_gen++;
        cmd_r1(6'd17, 32'd9, 8'h01, 8'h00, "cs");
        read_to_token(gap, b);
        check("cs_token", b, 8'hFE);
        for (int i = 0; i < 100; i++) read_byte(b);
        check("cs_byte99", b, 8'd99);
        @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b1;
        #1;
        check("cs_miso", miso, 1);
        check("cs_abort", rd_abort, 1);
        repeat (3) bit_cycle(1'b1, m);
        check("cs_miso_hold", m, 1);
        check("cs_abort_cnt", n_abort - ab0, 1);
        cs_n = 1'b0;
        cmd_r1(6'd0, 32'd0, 8'h95, 8'h01, "cs_cmd0");
        check("cs_cmd0_idle", in_idle, 1);

        // Backend stalls at byte 10.
        cmd_r1(6'd55, 32'd0, 8'h65, 8'h01, "ur55");
        cmd_r1(6'd41, 32'h4000_0000, 8'h77, 8'h00, "ur41");
        ab0 = n_abort;
        be_hold = 10;
        be_gen++;
        cmd_r1(6'd17, 32'd7, 8'h01, 8'h00, "ur");
        read_to_token(gap, b);
        check("ur_token", b, 8'hFE);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            read_byte(b);
            if (b !== i[7:0]) errs++;
        end
        check("ur_payload_errs", errs, 0);
        read_byte(b);
        check("ur_ones", b, 8'hFF);
        check("ur_flag", underrun, 1);
        check("ur_abort_cnt", n_abort - ab0, 1);
        cmd_r1(6'd0, 32'd0, 8'h95, 8'h01, "ur_cmd0");
        check("ur_flag_cleared", underrun, 0);

        idle_bits(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
